// File: rtl/soc_design_timer_sched_pkg.sv
// Shared constants, FSM state type and sizing helper for the software-timer scheduler.
package soc_design_timer_sched_pkg;

   localparam logic [2:0] ADDR_STATUS    = 3'd0;
   localparam logic [2:0] ADDR_IRQ_MASK  = 3'd1;
   localparam logic [2:0] ADDR_CH_SEL    = 3'd2;
   localparam logic [2:0] ADDR_CH_PERIOD = 3'd3;
   localparam logic [2:0] ADDR_CH_CTRL   = 3'd4;
   localparam logic [2:0] ADDR_CH_COUNT  = 3'd5;
   localparam logic [2:0] ADDR_OVERRUN   = 3'd6;
   localparam logic [2:0] ADDR_RSVD      = 3'd7;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_PERIODIC = 1;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } sched_state_e;

   function automatic int chan_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/soc_design_timer_sched_chan_bank.sv
// Per-channel period/count/enable/periodic storage with a CPU port and a scan port.
// A CPU write to the channel under scan suppresses that cycle's scan update.
module soc_design_timer_sched_chan_bank
   import soc_design_timer_sched_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16,
   parameter int CW     = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [CW-1:0]    cpu_sel_i,
   input  logic             cpu_we_period_i,
   input  logic             cpu_we_ctrl_i,
   input  logic [CNT_W-1:0] cpu_period_i,
   input  logic             cpu_en_i,
   input  logic             cpu_periodic_i,
   output logic [CNT_W-1:0] cpu_period_o,
   output logic [CNT_W-1:0] cpu_count_o,
   output logic             cpu_en_o,
   output logic             cpu_periodic_o,
   input  logic [CW-1:0]    scan_idx_i,
   input  logic             scan_we_i,
   input  logic [CNT_W-1:0] scan_count_i,
   input  logic             scan_en_i,
   output logic [CNT_W-1:0] scan_period_o,
   output logic [CNT_W-1:0] scan_count_o,
   output logic             scan_en_o,
   output logic             scan_periodic_o,
   output logic             scan_hit_o
);

   logic [CNT_W-1:0]  period_q [NUM_CH];
   logic [CNT_W-1:0]  period_d [NUM_CH];
   logic [CNT_W-1:0]  count_q  [NUM_CH];
   logic [CNT_W-1:0]  count_d  [NUM_CH];
   logic [NUM_CH-1:0] en_q, en_d;
   logic [NUM_CH-1:0] per_q, per_d;

   assign cpu_period_o    = period_q[cpu_sel_i];
   assign cpu_count_o     = count_q[cpu_sel_i];
   assign cpu_en_o        = en_q[cpu_sel_i];
   assign cpu_periodic_o  = per_q[cpu_sel_i];
   assign scan_period_o   = period_q[scan_idx_i];
   assign scan_count_o    = count_q[scan_idx_i];
   assign scan_en_o       = en_q[scan_idx_i];
   assign scan_periodic_o = per_q[scan_idx_i];
   assign scan_hit_o      = (cpu_we_period_i || cpu_we_ctrl_i) && (cpu_sel_i == scan_idx_i);

   // Next-state of the channel arrays; CPU writes are applied last so they win.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         period_d[c] = period_q[c];
         count_d[c]  = count_q[c];
      end
      en_d  = en_q;
      per_d = per_q;
      if (scan_we_i && !scan_hit_o) begin
         count_d[scan_idx_i] = scan_count_i;
         en_d[scan_idx_i]    = scan_en_i;
      end else begin
         en_d = en_q;
      end
      if (cpu_we_period_i) begin
         period_d[cpu_sel_i] = cpu_period_i;
      end else begin
         per_d = per_d;
      end
      if (cpu_we_ctrl_i) begin
         en_d[cpu_sel_i]    = cpu_en_i;
         per_d[cpu_sel_i]   = cpu_periodic_i;
         count_d[cpu_sel_i] = cpu_en_i ? period_q[cpu_sel_i] : '0;
      end else begin
         per_d = per_d;
      end
   end

   // Channel state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            period_q[c] <= '0;
            count_q[c]  <= '0;
         end
         en_q  <= '0;
         per_q <= '0;
      end else begin
         period_q <= period_d;
         count_q  <= count_d;
         en_q     <= en_d;
         per_q    <= per_d;
      end
   end

endmodule

// File: rtl/soc_design_timer_sched.sv
// Multi-channel timer scheduler: serial scan of NUM_CH countdown channels per timebase tick.
// Optional TIMER_SCHED_OVERRUN_EN adds a saturating dropped-tick counter at address 6.
module soc_design_timer_sched
   import soc_design_timer_sched_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic        irq
);

   localparam int CW = chan_idx_w(NUM_CH);

   sched_state_e      state_q, state_d;
   logic [CW-1:0]     idx_q, idx_d;
   logic              tick_pend_q, tick_pend_d;
   logic [NUM_CH-1:0] pending_q, pending_d;
   logic [NUM_CH-1:0] mask_q, mask_d;
   logic [CW-1:0]     sel_q, sel_d;
   logic [15:0]       readdata_q, readdata_d;

   logic              wr_s;
   logic [CNT_W-1:0]  cpu_period_s, cpu_count_s;
   logic              cpu_en_s, cpu_periodic_s;
   logic [CNT_W-1:0]  scan_period_s, scan_count_s, vis_count_s;
   logic              scan_en_s, scan_periodic_s, scan_hit_s, vis_en_s, fire_s;
   logic [NUM_CH-1:0] set_s, clr_s;
   logic [15:0]       ovr_rd_s;

   assign wr_s = chipselect && !write_n;

   soc_design_timer_sched_chan_bank #(
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W),
      .CW     (CW)
   ) u_bank (
      .clk             (clk),
      .reset           (reset),
      .cpu_sel_i       (sel_q),
      .cpu_we_period_i (wr_s && (address == ADDR_CH_PERIOD)),
      .cpu_we_ctrl_i   (wr_s && (address == ADDR_CH_CTRL)),
      .cpu_period_i    (writedata[CNT_W-1:0]),
      .cpu_en_i        (writedata[CTRL_EN]),
      .cpu_periodic_i  (writedata[CTRL_PERIODIC]),
      .cpu_period_o    (cpu_period_s),
      .cpu_count_o     (cpu_count_s),
      .cpu_en_o        (cpu_en_s),
      .cpu_periodic_o  (cpu_periodic_s),
      .scan_idx_i      (idx_q),
      .scan_we_i       (state_q == SCAN),
      .scan_count_i    (vis_count_s),
      .scan_en_i       (vis_en_s),
      .scan_period_o   (scan_period_s),
      .scan_count_o    (scan_count_s),
      .scan_en_o       (scan_en_s),
      .scan_periodic_o (scan_periodic_s),
      .scan_hit_o      (scan_hit_s)
   );

   // Shared decrementer: visit result for the channel at idx_q.
   always_comb begin
      vis_count_s = scan_count_s;
      vis_en_s    = scan_en_s;
      fire_s      = 1'b0;
      if ((state_q == SCAN) && scan_en_s) begin
         if (scan_count_s > CNT_W'(1)) begin
            vis_count_s = scan_count_s - CNT_W'(1);
         end else if (scan_count_s == CNT_W'(1)) begin
            fire_s = 1'b1;
            if (scan_periodic_s) begin
               vis_count_s = scan_period_s;
            end else begin
               vis_count_s = '0;
               vis_en_s    = 1'b0;
            end
         end else begin
            vis_count_s = scan_count_s;
         end
      end else begin
         fire_s = 1'b0;
      end
   end

   // Scan sequencer with one-deep tick buffer.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      tick_pend_d = tick_pend_q;
      case (state_q)
         IDLE: begin
            if (tick || tick_pend_q) begin
               state_d     = SCAN;
               idx_d       = '0;
               tick_pend_d = 1'b0;
            end else begin
               idx_d = idx_q;
            end
         end
         SCAN: begin
            if (tick) begin
               tick_pend_d = 1'b1;
            end else begin
               tick_pend_d = tick_pend_q;
            end
            if (idx_q == CW'(NUM_CH - 1)) begin
               state_d = IDLE;
            end else begin
               idx_d = idx_q + CW'(1);
            end
         end
         default: begin
            state_d     = IDLE;
            idx_d       = '0;
            tick_pend_d = 1'b0;
         end
      endcase
   end

   // Pending (expiry set beats W1C), mask and channel select.
   always_comb begin
      set_s = '0;
      if (fire_s && !scan_hit_s) begin
         set_s[idx_q] = 1'b1;
      end else begin
         set_s = '0;
      end
      clr_s     = (wr_s && (address == ADDR_STATUS)) ? writedata[NUM_CH-1:0] : '0;
      pending_d = (pending_q & ~clr_s) | set_s;
      mask_d    = (wr_s && (address == ADDR_IRQ_MASK)) ? writedata[NUM_CH-1:0] : mask_q;
      if (wr_s && (address == ADDR_CH_SEL) && (writedata < 16'(NUM_CH))) begin
         sel_d = writedata[CW-1:0];
      end else begin
         sel_d = sel_q;
      end
   end

`ifdef TIMER_SCHED_OVERRUN_EN
   logic [15:0] ovr_q, ovr_d;
   logic        drop_s;

   assign drop_s   = tick && tick_pend_q;
   assign ovr_rd_s = ovr_q;

   // Saturating overrun counter; a clear write beats a simultaneous drop.
   always_comb begin
      if (wr_s && (address == ADDR_OVERRUN)) begin
         ovr_d = 16'h0000;
      end else if (drop_s && (ovr_q != 16'hFFFF)) begin
         ovr_d = ovr_q + 16'h0001;
      end else begin
         ovr_d = ovr_q;
      end
   end

   // Overrun counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovr_q <= 16'h0000;
      end else begin
         ovr_q <= ovr_d;
      end
   end
`else
   assign ovr_rd_s = 16'h0000;
`endif

   // Read mux into the registered readdata.
   always_comb begin
      readdata_d = 16'h0000;
      case (address)
         ADDR_STATUS:    readdata_d[NUM_CH-1:0] = pending_q;
         ADDR_IRQ_MASK:  readdata_d[NUM_CH-1:0] = mask_q;
         ADDR_CH_SEL:    readdata_d[CW-1:0]     = sel_q;
         ADDR_CH_PERIOD: readdata_d[CNT_W-1:0]  = cpu_period_s;
         ADDR_CH_CTRL:   readdata_d[1:0]        = {cpu_periodic_s, cpu_en_s};
         ADDR_CH_COUNT:  readdata_d[CNT_W-1:0]  = cpu_count_s;
         ADDR_OVERRUN:   readdata_d             = ovr_rd_s;
         ADDR_RSVD:      readdata_d             = 16'h0000;
         default:        readdata_d             = 16'h0000;
      endcase
   end

   // Control and status registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         tick_pend_q <= 1'b0;
         pending_q   <= '0;
         mask_q      <= '0;
         sel_q       <= '0;
         readdata_q  <= 16'h0000;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         tick_pend_q <= tick_pend_d;
         pending_q   <= pending_d;
         mask_q      <= mask_d;
         sel_q       <= sel_d;
         readdata_q  <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(pending_q & mask_q);

endmodule

// File: tb/tb_soc_design_timer_sched.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level behavioural model.
module tb_soc_design_timer_sched;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 16;
   localparam int CHMASK = (1 << NUM_CH) - 1;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        tick = 1'b0;
   logic [2:0]  address = 3'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [15:0] writedata = 16'h0000;
   logic [15:0] readdata;
   logic        irq;

   always #5 clk = ~clk;

   soc_design_timer_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int irq_rises = 0;
   bit irq_prev = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Behavioural model: channels as integer counters, scan as a position in 0..NUM_CH-1
   int m_period [NUM_CH];
   int m_count  [NUM_CH];
   bit m_en     [NUM_CH];
   bit m_per    [NUM_CH];
   int m_pending, m_mask, m_sel, m_ovr, m_rd, m_pos;
   bit m_scanning, m_tpend;

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_period[c] = 0; m_count[c] = 0; m_en[c] = 0; m_per[c] = 0;
      end
      m_pending = 0; m_mask = 0; m_sel = 0; m_ovr = 0; m_rd = 0;
      m_pos = 0; m_scanning = 0; m_tpend = 0;
   endtask

   function automatic int model_read(input int a);
      case (a)
         0: return m_pending;
         1: return m_mask;
         2: return m_sel;
         3: return m_period[m_sel];
         4: return (int'(m_per[m_sel]) << 1) | int'(m_en[m_sel]);
         5: return m_count[m_sel];
`ifdef TIMER_SCHED_OVERRUN_EN
         6: return m_ovr;
`endif
         default: return 0;
      endcase
   endfunction

   task automatic model_step(input bit r, input bit t, input bit cs, input bit wn, input int a, input int d);
      bit w;
      int rd, setv, c;
      if (r) begin
         model_reset();
         return;
      end
      w = cs && !wn;
      rd = model_read(a);
      setv = 0;
      if (m_scanning) begin
         c = m_pos;
         if (!(w && (a == 3 || a == 4) && m_sel == c) && m_en[c]) begin
            if (m_count[c] > 1) m_count[c] = m_count[c] - 1;
            else if (m_count[c] == 1) begin
               setv = 1 << c;
               if (m_per[c]) m_count[c] = m_period[c];
               else begin m_count[c] = 0; m_en[c] = 0; end
            end
         end
      end
      if (w) begin
         case (a)
            0: m_pending = m_pending & ~d;
            1: m_mask = d & CHMASK;
            2: if (d < NUM_CH) m_sel = d;
            3: m_period[m_sel] = d;
            4: begin
               m_en[m_sel]    = d[0];
               m_per[m_sel]   = d[1];
               m_count[m_sel] = d[0] ? m_period[m_sel] : 0;
            end
            default: ;
         endcase
      end
      m_pending = (m_pending | setv) & CHMASK;
      if (w && a == 6) m_ovr = 0;
      else if (t && m_tpend && m_ovr < 65535) m_ovr = m_ovr + 1;
      if (!m_scanning) begin
         if (t || m_tpend) begin m_scanning = 1; m_pos = 0; m_tpend = 0; end
      end else begin
         if (t) m_tpend = 1;
         if (m_pos == NUM_CH - 1) m_scanning = 0;
         else m_pos = m_pos + 1;
      end
      m_rd = rd;
   endtask

   task automatic cyc(input bit r, input bit t, input bit cs, input bit wn, input int a, input int d);
      @(negedge clk);
      reset = r; tick = t; chipselect = cs; write_n = wn;
      address = 3'(a); writedata = 16'(d);
      @(posedge clk);
      model_step(r, t, cs, wn, a, d & 32'hFFFF);
      #1;
      check_val("readdata", 32'(readdata), 32'(m_rd));
      check_val("irq", 32'(irq), 32'((m_pending & m_mask) != 0));
      if (irq && !irq_prev) irq_rises++;
      irq_prev = irq;
   endtask

   task automatic wr(input int a, input int d); cyc(0, 0, 1, 0, a, d); endtask
   task automatic rd(input int a);              cyc(0, 0, 1, 1, a, 0); endtask
   task automatic tk();                         cyc(0, 1, 0, 1, 0, 0); endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, 0);
   endtask

   initial begin
      model_reset();
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 0, 0);

      // reset state on every address
      for (int a = 0; a < 8; a++) begin
         rd(a);
         check_val("rst_read", 32'(readdata), 32'h0);
      end
      check_val("rst_irq", 32'(irq), 32'h0);

      // ch0 periodic, period 3
      wr(2, 0); wr(3, 3); wr(4, 3); wr(1, 1);
      irq_rises = 0;
      for (int k = 1; k <= 9; k++) begin
         tk();
         idle(19);
         check_val("ch0_irq_tick", 32'(irq), 32'(k % 3 == 0));
         wr(0, 1);
         check_val("ch0_w1c_irq", 32'(irq), 32'h0);
      end
      check_val("ch0_rises", 32'(irq_rises), 32'd3);

      // ch2 one-shot, period 2
      wr(2, 2); wr(3, 2); wr(4, 1);
      tk(); idle(10); tk(); idle(10);
      rd(4); check_val("ch2_ctrl", 32'(readdata), 32'h0);
      rd(5); check_val("ch2_count", 32'(readdata), 32'h0);
      rd(0); check_val("ch2_pend", 32'(readdata[2]), 32'h1);
      wr(0, 4);
      tk(); idle(10); tk(); idle(10);
      rd(0); check_val("ch2_nofire", 32'(readdata[2]), 32'h0);

      // closely spaced ticks: buffered, then overrun
      idle(8); wr(6, 0);
      tk(); idle(1); tk(); idle(1); tk(); idle(12);
      rd(6);
`ifdef TIMER_SCHED_OVERRUN_EN
      check_val("overrun", 32'(readdata), 32'h1);
`else
      check_val("overrun", 32'(readdata), 32'h0);
`endif

      // expiry beats W1C of the same bit
      wr(2, 1); wr(3, 1); wr(4, 1); wr(0, 15); idle(8);
      tk(); idle(1); wr(0, 2);
      rd(0); check_val("set_wins", 32'(readdata[1]), 32'h1);

      // reset in the middle of a scan
      wr(2, 3); wr(3, 5); wr(4, 3); wr(1, 15); idle(6);
      tk(); idle(2);
      cyc(1, 0, 1, 1, 5, 0);
      check_val("midrst_rd", 32'(readdata), 32'h0);
      check_val("midrst_irq", 32'(irq), 32'h0);
      rd(5); check_val("midrst_cnt0", 32'(readdata), 32'h0);
      wr(2, 3); rd(5); check_val("midrst_cnt3", 32'(readdata), 32'h0);
      rd(4); check_val("midrst_ctrl3", 32'(readdata), 32'h0);

      // random traffic against the model
      for (int n = 0; n < 4000; n++) begin
         int a, d, r;
         bit t, cs, wn, rs;
         r  = $urandom_range(0, 99);
         t  = ($urandom_range(0, 5) == 0);
         rs = ($urandom_range(0, 799) == 0);
         a  = $urandom_range(0, 7);
         case (a)
            2: d = $urandom_range(0, 5);
            3: d = $urandom_range(0, 4);
            4: d = $urandom_range(0, 3);
            default: d = $urandom_range(0, 65535);
         endcase
         if (r < 30) begin cs = 1; wn = 0; end
         else if (r < 40) begin cs = 0; wn = 0; end
         else begin cs = $urandom_range(0, 1); wn = 1; end
         cyc(rs, t, cs, wn, a, d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/soc_design_timer_sched.md
# soc_design_timer_sched

Multi-channel software-timer scheduler that shares the single periodic timeout tick of the system interval timer among NUM_CH independent countdown channels. On each tick, a serial scan engine visits every channel once through one shared decrementer, reloading or retiring each channel and latching per-channel expiry flags. It sits beside the interval timer on the Avalon-MM control bus: the timer's timeout pulse is its timebase, and its single irq replaces per-client polling of the timer status.

## Interface
- NUM_CH, 4, number of channels (1..16); channel index width CW = max(1, clog2(NUM_CH))
- CNT_W, 16, channel period/count width (≤16, fits one bus word)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- tick  in  1  single-cycle timebase pulse from the interval timer timeout
- address  in  3  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  16  write data
- readdata  out  16  registered read data
- irq  out  1  OR of (pending & irq_mask)

## Operation
- Register map: 0 STATUS (pending[NUM_CH-1:0], write-1-to-clear); 1 IRQ_MASK (rw); 2 CH_SEL (rw, CW bits, values ≥NUM_CH ignored); 3 CH_PERIOD[CH_SEL] (rw); 4 CH_CTRL[CH_SEL] (bit0 enable, bit1 periodic, rw); 5 CH_COUNT[CH_SEL] (ro); 6 OVERRUN (see Configuration); 7 reads 0. Unused bits read 0.
- Writing CH_CTRL with enable=1 loads count ← period (restart). Writing enable=0 clears count to 0. A CH_PERIOD write takes effect only at the next reload or restart.
- FSM states: IDLE, SCAN. In IDLE, tick or tick_pend → SCAN with idx=0, and tick_pend clears. SCAN visits channel idx per cycle. After idx=NUM_CH-1 it returns to IDLE.
- Visit rule when enable=1: count>1 → count−1. count==1 → set pending[idx]; if periodic, count ← period; else count ← 0 and enable ← 0. count==0 → no action. Enable=0: no action.
- A period of 0 never fires.
- A tick arriving while in SCAN sets tick_pend (one deep). A tick arriving while tick_pend is already set is an overrun and is dropped.
- Simultaneous events:
  - CPU write to CH_CTRL/CH_PERIOD of the channel being visited in the same cycle: CPU write wins, visit result discarded.
  - Expiry setting pending[i] in the same cycle as a W1C of bit i: set wins.
  - tick in the last SCAN cycle: sets tick_pend, next scan starts after one IDLE cycle.
- Mid-operation reset returns the FSM to IDLE and clears all state, including tick_pend.

## Timing
- Reset values:
  - readdata=0, irq=0, pending=0, irq_mask=0, CH_SEL=0.
  - All period/count/enable/periodic=0; OVERRUN=0; FSM=IDLE.
- tick at edge T: SCAN from T+1, channel i visited in cycle T+1+i. pending[i] and irq are visible from T+2+i.
- irq is combinational from flops: 0 cycles after pending/mask change.
- Read latency is 1 cycle: readdata reflects the register at the address sampled on the prior edge. readdata updates every cycle regardless of chipselect.
- Writes take effect on the edge where chipselect && !write_n.
- Ticks spaced ≥NUM_CH+1 cycles are never buffered or lost.

## Configuration
- TIMER_SCHED_OVERRUN_EN defined:
  - 16-bit saturating OVERRUN counter increments on each dropped tick.
  - Address 6 reads it; any write to address 6 clears it.
  - The write clears it even if an overrun occurs in the same cycle; the count then restarts at 0.
- Undefined: the counter logic is absent, address 6 reads 0, and dropped ticks are silently discarded.

## Structure
- Package soc_design_timer_sched_pkg holds:
  - register address constants (ADDR_STATUS…ADDR_OVERRUN)
  - CH_CTRL bit positions (CTRL_EN=0, CTRL_PERIODIC=1)
  - FSM state enum (IDLE, SCAN)
- Sub-module soc_design_timer_sched_chan_bank: the per-channel period/count/enable/periodic arrays.
  - One CPU port addressed by CH_SEL.
  - One scan port addressed by idx, with read and update.
  - CPU-wins priority is resolved inside the bank.
- The top level holds the FSM, the shared decrementer, pending/mask, the overrun logic and the read mux.

## Test plan
- Reset, then read all addresses → readdata 0 everywhere, irq=0.
- ch0 period=3, periodic, mask=1; pulse tick every 20 cycles → pending[0] on ticks 3, 6, 9; irq rises 2 cycles after each of those ticks; W1C STATUS=1 clears irq.
- ch2 period=2, one-shot → fires once after tick 2; CH_CTRL then reads enable=0, CH_COUNT reads 0; no further pending.
- Ticks 2 cycles apart with NUM_CH=4 → second tick buffered (scan restarts after IDLE); third tick during the same scan → OVERRUN=1 (macro on) or address 6 reads 0 (macro off).
- W1C of pending[1] in the same cycle that ch1 expires → pending[1] remains 1.
- Assert reset during SCAN at idx=2 → next cycle FSM IDLE, all counts 0, irq=0, readdata=0.
